// File: rtl/int_predecode.sv
// Interrupt pre-decoder: sits between the data bus and the PLA sequencer.
// On every opcode fetch it either passes the fetched byte through, or, when
// a reset/NMI/IRQ request is pending, injects a forced BRK (0x00) together
// with the interrupt type that the vector-fetch microcode needs.
// NMI is edge-captured, IRQ is level-sensitive and masked by the I flag.
module int_predecode (
    input  logic       phi1,
    input  logic       rst,
    input  logic [7:0] dataIn,
    input  logic       SYNC,
    input  logic       RDY,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       iFlag,
    input  logic       intAck,
    output logic [7:0] opcodeOut,
    output logic [1:0] intType,
    output logic       forcedBrk,
    output logic       nmiPend,
    output logic       irqPend,
    output logic       rstPend
);

    localparam logic [1:0] ST_RESET_SEQ = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_INT_SEQ   = 2'd2;

    localparam logic [1:0] IT_NONE = 2'b00;
    localparam logic [1:0] IT_IRQ  = 2'b01;
    localparam logic [1:0] IT_NMI  = 2'b10;
    localparam logic [1:0] IT_RST  = 2'b11;

    logic [1:0] state;
    logic       nmi_sync_p0, nmi_sync_p1, nmi_prev_p2;
    logic       irq_sync_p0, irq_sync_p1;
    logic       nmi_latch;
    logic       rst_pend;
    logic       nmi_edge;
    logic       fetch;
    logic       ack;

    // Two-flop synchronizers for the async pins, plus one extra NMI flop for
    // falling-edge detection; all idle high so reset never looks like an edge
    always_ff @(posedge phi1 or negedge rst) begin
        if (!rst) begin
            nmi_sync_p0 <= 1'b1;
            nmi_sync_p1 <= 1'b1;
            nmi_prev_p2 <= 1'b1;
            irq_sync_p0 <= 1'b1;
            irq_sync_p1 <= 1'b1;
        end else begin
            nmi_sync_p0 <= nmi_n;
            nmi_sync_p1 <= nmi_sync_p0;
            nmi_prev_p2 <= nmi_sync_p1;
            irq_sync_p0 <= irq_n;
            irq_sync_p1 <= irq_sync_p0;
        end
    end

    assign nmi_edge = nmi_prev_p2 & ~nmi_sync_p1;
    assign fetch    = SYNC & RDY;
    assign ack      = intAck & RDY & (state == ST_INT_SEQ);

    assign nmiPend  = nmi_latch;
    assign irqPend  = ~irq_sync_p1 & ~iFlag;
    assign rstPend  = rst_pend;

    // NMI latch: set by a synchronized falling edge, cleared by its own
    // acknowledge; a fresh edge in the acknowledge cycle must not be lost
    always_ff @(posedge phi1 or negedge rst) begin
        if (!rst) begin
            nmi_latch <= 1'b0;
        end else if (nmi_edge) begin
            nmi_latch <= 1'b1;
        end else if (ack && (intType == IT_NMI)) begin
            nmi_latch <= 1'b0;
        end
    end

    // Reset request stays pending until the reset vector fetch is acknowledged
    always_ff @(posedge phi1 or negedge rst) begin
        if (!rst) begin
            rst_pend <= 1'b1;
        end else if (ack && (intType == IT_RST)) begin
            rst_pend <= 1'b0;
        end
    end

    // Sequencing FSM and registered opcode / interrupt-type outputs
    always_ff @(posedge phi1 or negedge rst) begin
        if (!rst) begin
            state     <= ST_RESET_SEQ;
            opcodeOut <= 8'h00;
            forcedBrk <= 1'b1;
            intType   <= IT_RST;
        end else begin
            case (state)
                ST_RESET_SEQ: begin
                    opcodeOut <= 8'h00;
                    forcedBrk <= 1'b1;
                    intType   <= IT_RST;
                    if (fetch) begin
                        state <= ST_INT_SEQ;
                    end
                end
                ST_RUN: begin
                    if (fetch) begin
                        if (rst_pend) begin
                            opcodeOut <= 8'h00;
                            forcedBrk <= 1'b1;
                            intType   <= IT_RST;
                            state     <= ST_INT_SEQ;
                        end else if (nmi_latch) begin
                            opcodeOut <= 8'h00;
                            forcedBrk <= 1'b1;
                            intType   <= IT_NMI;
                            state     <= ST_INT_SEQ;
                        end else if (irqPend) begin
                            opcodeOut <= 8'h00;
                            forcedBrk <= 1'b1;
                            intType   <= IT_IRQ;
                            state     <= ST_INT_SEQ;
                        end else begin
                            opcodeOut <= dataIn;
                            forcedBrk <= 1'b0;
                            intType   <= IT_NONE;
                        end
                    end
                end
                ST_INT_SEQ: begin
                    // Opcode is held for the whole vector sequence; only the
                    // type and forced flag drop when the sequencer acknowledges
                    if (ack) begin
                        forcedBrk <= 1'b0;
                        intType   <= IT_NONE;
                        state     <= ST_RUN;
                    end
                end
                default: begin
                    state     <= ST_RESET_SEQ;
                    opcodeOut <= 8'h00;
                    forcedBrk <= 1'b1;
                    intType   <= IT_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_predecode.sv
// Self-checking bench for int_predecode: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_int_predecode;

    logic       phi1 = 1'b0;
    logic       rst;
    logic [7:0] dataIn;
    logic       SYNC, RDY, nmi_n, irq_n, iFlag, intAck;
    logic [7:0] opcodeOut;
    logic [1:0] intType;
    logic       forcedBrk, nmiPend, irqPend, rstPend;

    int checks   = 0;
    int failures = 0;

    int_predecode dut (
        .phi1     (phi1),
        .rst      (rst),
        .dataIn   (dataIn),
        .SYNC     (SYNC),
        .RDY      (RDY),
        .nmi_n    (nmi_n),
        .irq_n    (irq_n),
        .iFlag    (iFlag),
        .intAck   (intAck),
        .opcodeOut(opcodeOut),
        .intType  (intType),
        .forcedBrk(forcedBrk),
        .nmiPend  (nmiPend),
        .irqPend  (irqPend),
        .rstPend  (rstPend)
    );

    always #5 phi1 = ~phi1;

    // ---------------- reference model ----------------
    localparam int M_RESET = 0;
    localparam int M_RUN   = 1;
    localparam int M_INT   = 2;

    int         m_state;
    logic [7:0] m_op;
    logic [1:0] m_type;
    logic       m_fb, m_nmi, m_rst;
    bit         nmi_samples[$];   // pin values seen at past edges, newest last
    bit         irq_samples[$];

    function automatic bit nmi_seen(input int ago);
        // value of nmi_n as sampled 'ago' edges back (1 before any sample)
        if (nmi_samples.size() < ago) return 1'b1;
        return nmi_samples[nmi_samples.size() - ago];
    endfunction

    function automatic bit m_irq_pend();
        bit synced;
        synced = (irq_samples.size() < 2) ? 1'b1 : irq_samples[irq_samples.size() - 2];
        return !synced && !iFlag;
    endfunction

    task automatic model_reset();
        m_state = M_RESET;
        m_op = 8'h00; m_fb = 1'b1; m_type = 2'b11;
        m_rst = 1'b1; m_nmi = 1'b0;
        nmi_samples.delete();
        irq_samples.delete();
    endtask

    task automatic model_edge();
        bit edge_now;
        // pin low two edges ago after being high three edges ago
        edge_now = !nmi_seen(2) && nmi_seen(3);
        case (m_state)
            M_RESET: if (SYNC && RDY) m_state = M_INT;
            M_RUN: if (SYNC && RDY) begin
                if (m_rst)             m_type = 2'b11;
                else if (m_nmi)        m_type = 2'b10;
                else if (m_irq_pend()) m_type = 2'b01;
                else                   m_type = 2'b00;
                if (m_type == 2'b00) begin
                    m_op = dataIn; m_fb = 1'b0;
                end else begin
                    m_op = 8'h00; m_fb = 1'b1; m_state = M_INT;
                end
            end
            default: if (intAck && RDY) begin
                if (m_type == 2'b10) m_nmi = 1'b0;
                if (m_type == 2'b11) m_rst = 1'b0;
                m_type = 2'b00; m_fb = 1'b0; m_state = M_RUN;
            end
        endcase
        if (edge_now) m_nmi = 1'b1;
        nmi_samples.push_back(nmi_n);
        irq_samples.push_back(irq_n);
        if (nmi_samples.size() > 4) void'(nmi_samples.pop_front());
        if (irq_samples.size() > 4) void'(irq_samples.pop_front());
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".op"},   opcodeOut,        m_op);
        chk({tag, ".type"}, {6'd0, intType},  {6'd0, m_type});
        chk({tag, ".fb"},   {7'd0, forcedBrk}, {7'd0, m_fb});
        chk({tag, ".nmi"},  {7'd0, nmiPend},  {7'd0, m_nmi});
        chk({tag, ".irq"},  {7'd0, irqPend},  {7'd0, m_irq_pend()});
        chk({tag, ".rstp"}, {7'd0, rstPend},  {7'd0, m_rst});
    endtask

    task automatic step(input string tag);
        @(posedge phi1);
        if (rst) model_edge();
        else     model_reset();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all({tag, ".async"});
        step(tag);
        rst = 1'b1;
    endtask

    task automatic idle();
        SYNC = 1'b0; intAck = 1'b0; RDY = 1'b1;
    endtask

    initial begin
        rst = 1'b1; dataIn = 8'h00; SYNC = 1'b0; RDY = 1'b1;
        nmi_n = 1'b1; irq_n = 1'b1; iFlag = 1'b1; intAck = 1'b0;
        model_reset();

        // Reset, reset vector sequence, first real opcode
        do_reset("rst0");
        chk("r031.type", {6'd0, intType}, 8'h03);
        chk("r031.rstp", {7'd0, rstPend}, 8'h01);
        SYNC = 1'b1; step("r031.fetch");
        SYNC = 1'b0; step("r031.wait");
        chk("r031.rstp_held", {7'd0, rstPend}, 8'h01);
        intAck = 1'b1; step("r031.ack");
        intAck = 1'b0;
        chk("r031.rstp_clr", {7'd0, rstPend}, 8'h00);
        SYNC = 1'b1; dataIn = 8'hA9; step("r031.op");
        chk("r031.opA9", opcodeOut, 8'hA9);
        chk("r031.fb0", {7'd0, forcedBrk}, 8'h00);

        // NMI edge latency and injection
        SYNC = 1'b0; nmi_n = 1'b0; step("r032.e0");
        step("r032.e1");
        chk("r032.e1_nopend", {7'd0, nmiPend}, 8'h00);
        step("r032.e2");
        chk("r032.e2_pend", {7'd0, nmiPend}, 8'h01);
        nmi_n = 1'b1;
        SYNC = 1'b1; dataIn = 8'hEA; step("r032.fetch");
        chk("r032.op0", opcodeOut, 8'h00);
        chk("r032.type", {6'd0, intType}, 8'h02);
        SYNC = 1'b1; dataIn = 8'h55; step("r032.sync_ignored");
        SYNC = 1'b0; intAck = 1'b1; step("r032.ack");
        intAck = 1'b0;
        chk("r032.nmi_clr", {7'd0, nmiPend}, 8'h00);

        // IRQ masked, then unmasked
        irq_n = 1'b0; iFlag = 1'b1; step("r033.s0"); step("r033.s1");
        SYNC = 1'b1; dataIn = 8'h18; step("r033.masked");
        chk("r033.op18", opcodeOut, 8'h18);
        iFlag = 1'b0; step("r033.taken");
        chk("r033.type", {6'd0, intType}, 8'h01);
        iFlag = 1'b1; SYNC = 1'b0; step("r033.iflag_late");
        chk("r033.type_held", {6'd0, intType}, 8'h01);
        iFlag = 1'b0; intAck = 1'b1; step("r033.ack");
        intAck = 1'b0;

        // NMI beats IRQ, then IRQ follows
        nmi_n = 1'b0; step("r034.e0"); step("r034.e1"); step("r034.e2");
        nmi_n = 1'b1;
        SYNC = 1'b1; dataIn = 8'h60; step("r034.fetch");
        chk("r034.nmi_first", {6'd0, intType}, 8'h02);
        SYNC = 1'b0; intAck = 1'b1; step("r034.ack");
        intAck = 1'b0;
        SYNC = 1'b1; step("r034.irq_next");
        chk("r034.irq_second", {6'd0, intType}, 8'h01);
        SYNC = 1'b0; intAck = 1'b1; step("r034.ack2");
        intAck = 1'b0; irq_n = 1'b1; iFlag = 1'b1; step("r034.idle");
        step("r034.idle2");

        // Stall: opcode held, NMI capture continues
        SYNC = 1'b1; dataIn = 8'h4C; RDY = 1'b0; nmi_n = 1'b0;
        step("r035.s0"); step("r035.s1"); step("r035.s2");
        chk("r035.op_held", opcodeOut, 8'h00);
        chk("r035.nmi_set", {7'd0, nmiPend}, 8'h01);
        RDY = 1'b1; nmi_n = 1'b1; step("r035.fetch");

        // Reset in the middle of an NMI vector sequence
        chk("r036.in_nmi", {6'd0, intType}, 8'h02);
        SYNC = 1'b0;
        do_reset("r036");
        chk("r036.type", {6'd0, intType}, 8'h03);
        chk("r036.nmi0", {7'd0, nmiPend}, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            SYNC   = ($urandom_range(0, 2) == 0);
            RDY    = ($urandom_range(0, 4) != 0);
            intAck = ($urandom_range(0, 3) == 0);
            dataIn = 8'($urandom);
            if ($urandom_range(0, 7) == 0)  iFlag = ~iFlag;
            if ($urandom_range(0, 9) == 0)  nmi_n = ~nmi_n;
            if ($urandom_range(0, 11) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            else                             step("rnd");
        end

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
